sequence_generator_moore: RTL and testbench

Serial pattern transmitter that produces the bit stream a sequence detector consumes. On a start request it shifts a fixed PAT_W-bit pattern out MSB-first, one bit per clock, a programmable number of times, with idle zero bits between frames. Moore machine: every output is a registered function of state. It sits upstream of the Mealy detector in self-checking benches and in on-chip loopback test paths.

---
 rtl/seq_gen_pkg.sv | 30 +++
 rtl/seq_down_counter.sv | 59 +++++
 rtl/sequence_generator_moore.sv | 214 +++++++++++++++++++++
 tb/tb_sequence_generator_moore.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
// Shared types and constants for the Moore serial pattern transmitter:
// FSM state encoding, default pattern/gap/width constants and the even-parity
// helper used for the optional parity bit.
// -----------------------------------------------------------------------------
package seq_gen_pkg;

  // Transmitter states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned PAT_W_DEFAULT   = 4;
  localparam logic [3:0]  PATTERN_DEFAULT = 4'b1010;
  localparam int unsigned GAP_DEFAULT     = 2;
  localparam int unsigned CNT_W_DEFAULT   = 8;

  // Gap lengths run 0..15, so a 4-bit gap counter always suffices
  localparam int unsigned GAP_CNT_W = 4;

  // Even-parity bit of a pattern: XOR of all bits (upper bits zero-padded)
  function automatic logic even_parity(input logic [31:0] pat);
    return ^pat;
  endfunction

endpackage : seq_gen_pkg

// File: rtl/seq_down_counter.sv
// -----------------------------------------------------------------------------
// seq_down_counter
// Loadable, saturating down-counter with a registered zero flag.
// Priority: clear > load > decrement.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (count -> 0, zero -> 1)
//   i_clr      in   synchronous clear to zero
//   i_load     in   load i_load_val
//   i_load_val in   W-bit load value
//   i_dec      in   decrement by one, holds at zero
//   o_count    out  current count
//   o_zero     out  high when o_count is zero
// -----------------------------------------------------------------------------
module seq_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;
  logic         r_zero;
  logic [W-1:0] w_next;

  // Next count value
  always_comb begin
    w_next = r_count;
    if (i_clr) begin
      w_next = '0;
    end else if (i_load) begin
      w_next = i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      w_next = r_count - W'(1);
    end
  end

  // Count and zero flag registers; the flag tracks the value being loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_zero  <= 1'b1;
    end else begin
      r_count <= w_next;
      r_zero  <= (w_next == '0);
    end
  end

  assign o_count = r_count;
  assign o_zero  = r_zero;

endmodule : seq_down_counter

// File: rtl/sequence_generator_moore.sv
// -----------------------------------------------------------------------------
// sequence_generator_moore
// Moore serial pattern transmitter. On an accepted start it shifts PATTERN out
// MSB-first, one bit per clock, num_frames times, with GAP idle zero bits
// between frames, then pulses done for one cycle. All outputs are registered.
//
// Optional feature macro: SEQ_GEN_PARITY_EN -- appends one even-parity bit to
// every frame (frame becomes PAT_W+1 bits; the gap follows the parity bit).
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   start       in   transmit request, sampled only in IDLE
//   abort       in   synchronous cancel, honoured in every state
//   num_frames  in   frame count, latched when start is accepted
//   out_seq     out  serial data bit
//   busy        out  high while sending frames or gap bits
//   done        out  one-cycle pulse after the last bit of the last frame
// -----------------------------------------------------------------------------
module sequence_generator_moore
  import seq_gen_pkg::*;
#(
  parameter int unsigned      PAT_W   = PAT_W_DEFAULT,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_DEFAULT),
  parameter int unsigned      GAP     = GAP_DEFAULT,
  parameter int unsigned      CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_frames,
  output logic             out_seq,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0]     BIT_MSB  = BIT_W'(PAT_W - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = (GAP == 0) ? '0 : GAP_CNT_W'(GAP - 1);
  localparam logic                 PAR_BIT  = even_parity(32'(PATTERN));

  state_e r_state;
  logic   r_out_seq;
  logic   r_busy;
  logic   r_done;

  logic [BIT_W-1:0]     w_bit_cnt;
  logic [BIT_W-1:0]     w_bit_prev;
  logic                 w_bit_zero;
  logic [GAP_CNT_W-1:0] w_gap_cnt_unused;
  logic                 w_gap_zero;
  logic [CNT_W-1:0]     w_frames_cnt;
  logic                 w_frames_zero_unused;

  logic w_accept;
  logic w_frame_end;
  logic w_last_frame;
  logic w_gap_exit;
  logic w_par_cycle;
  logic w_bit_load;
  logic w_bit_dec;
  logic w_gap_load;
  logic w_gap_dec;
  logic w_frames_load;
  logic w_frames_dec;

`ifdef SEQ_GEN_PARITY_EN
  logic r_par_phase;

  // Parity cycle: bit index exhausted but the parity bit is not yet out
  assign w_par_cycle = w_bit_zero && !r_par_phase;
`else
  assign w_par_cycle = 1'b0;
`endif

  assign w_bit_prev = w_bit_cnt - BIT_W'(1);

  // Counter control decode; shares its decisions with the state register
  always_comb begin
    w_accept      = (r_state == ST_IDLE) && start && !abort;
    w_frame_end   = (r_state == ST_SEND) && w_bit_zero && !w_par_cycle && !abort;
    w_last_frame  = (w_frames_cnt == CNT_W'(1));
    w_gap_exit    = (r_state == ST_GAP) && w_gap_zero && !abort;
    w_bit_load    = (w_accept && (num_frames != '0))
                  || (w_frame_end && !w_last_frame && (GAP == 0))
                  || w_gap_exit;
    w_bit_dec     = (r_state == ST_SEND) && !w_bit_zero && !abort;
    w_gap_load    = w_frame_end && !w_last_frame && (GAP != 0);
    w_gap_dec     = (r_state == ST_GAP) && !w_gap_zero && !abort;
    w_frames_load = w_accept;
    w_frames_dec  = w_frame_end;
  end

  // Index of the bit currently on out_seq
  seq_down_counter #(.W(BIT_W)) u_bit_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .i_clr      (abort),
    .i_load     (w_bit_load),
    .i_load_val (BIT_MSB),
    .i_dec      (w_bit_dec),
    .o_count    (w_bit_cnt),
    .o_zero     (w_bit_zero)
  );

  // Remaining gap cycles after the current one
  seq_down_counter #(.W(GAP_CNT_W)) u_gap_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .i_clr      (abort),
    .i_load     (w_gap_load),
    .i_load_val (GAP_LOAD),
    .i_dec      (w_gap_dec),
    .o_count    (w_gap_cnt_unused),
    .o_zero     (w_gap_zero)
  );

  // Frames still to send, including the one in flight
  seq_down_counter #(.W(CNT_W)) u_frames_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .i_clr      (abort),
    .i_load     (w_frames_load),
    .i_load_val (num_frames),
    .i_dec      (w_frames_dec),
    .o_count    (w_frames_cnt),
    .o_zero     (w_frames_zero_unused)
  );

  // FSM with registered Moore outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_out_seq <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      r_par_phase <= 1'b0;
`endif
    end else begin
      r_out_seq <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
`ifdef SEQ_GEN_PARITY_EN
        r_par_phase <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (num_frames != '0) begin
                r_state   <= ST_SEND;
                r_out_seq <= PATTERN[BIT_MSB];
                r_busy    <= 1'b1;
              end else begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end
          end

          ST_SEND: begin
            r_busy <= 1'b1;
            if (!w_bit_zero) begin
              r_out_seq <= PATTERN[w_bit_prev];
            end else if (w_par_cycle) begin
              r_out_seq <= PAR_BIT;
`ifdef SEQ_GEN_PARITY_EN
              r_par_phase <= 1'b1;
`endif
            end else begin
`ifdef SEQ_GEN_PARITY_EN
              r_par_phase <= 1'b0;
`endif
              if (w_last_frame) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (GAP == 0) begin
                r_out_seq <= PATTERN[BIT_MSB];
              end else begin
                r_state <= ST_GAP;
              end
            end
          end

          ST_GAP: begin
            r_busy <= 1'b1;
            if (w_gap_zero) begin
              r_state   <= ST_SEND;
              r_out_seq <= PATTERN[BIT_MSB];
            end
          end

          ST_DONE: begin
            r_state <= ST_IDLE;
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign out_seq = r_out_seq;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule : sequence_generator_moore

// File: tb/tb_sequence_generator_moore.sv
// -----------------------------------------------------------------------------
// tb_sequence_generator_moore
// Directed bench for sequence_generator_moore. Instance dut uses the default
// parameters (PATTERN 1010, GAP 2); instance dut_g0 uses GAP 0. Expected bit
// streams are hand-written for both the default and SEQ_GEN_PARITY_EN builds.
// -----------------------------------------------------------------------------
module tb_sequence_generator_moore;

`ifdef SEQ_GEN_PARITY_EN
  localparam int unsigned FR    = 5;
  localparam int unsigned N_TWO = 12;
  localparam logic [15:0] EXP_TWO = 16'b0000_10100_00_10100;
  localparam int unsigned N_B2B = 15;
  localparam logic [15:0] EXP_B2B = 16'b0_10100_10100_10100;
  localparam logic [15:0] EXP_ONE = 16'b00000000000_10100;
`else
  localparam int unsigned FR    = 4;
  localparam int unsigned N_TWO = 10;
  localparam logic [15:0] EXP_TWO = 16'b000000_1010_00_1010;
  localparam int unsigned N_B2B = 12;
  localparam logic [15:0] EXP_B2B = 16'b0000_1010_1010_1010;
  localparam logic [15:0] EXP_ONE = 16'b000000000000_1010;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] num_frames;
  logic       out_seq;
  logic       busy;
  logic       done;

  logic       g_start;
  logic       g_abort;
  logic [7:0] g_num_frames;
  logic       g_out_seq;
  logic       g_busy;
  logic       g_done;

  int n_checks = 0;
  int n_errors = 0;

  sequence_generator_moore dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .num_frames (num_frames),
    .out_seq    (out_seq),
    .busy       (busy),
    .done       (done)
  );

  sequence_generator_moore #(.GAP(0)) dut_g0 (
    .clk        (clk),
    .rst        (rst),
    .start      (g_start),
    .abort      (g_abort),
    .num_frames (g_num_frames),
    .out_seq    (g_out_seq),
    .busy       (g_busy),
    .done       (g_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #3;
    n_checks++;
    if ({out_seq, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b expected 000", {out_seq, busy, done});
    end
    n_checks++;
    if ({g_out_seq, g_busy, g_done} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_outputs_g0: got %b expected 000", {g_out_seq, g_busy, g_done});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_seq, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL idle_after_reset: got %b expected 000", {out_seq, busy, done});
    end
  endtask

  task automatic test_two_frames();
    logic [15:0] e;
    logic [3:0]  sh;
    int          det;
    e   = EXP_TWO;
    sh  = 4'b0000;
    det = 0;
    start = 1'b1;
    num_frames = 8'd2;
    @(negedge clk);
    start = 1'b0;
    num_frames = 8'd7;
    for (int i = 0; i < int'(N_TWO); i++) begin
      n_checks++;
      if (out_seq !== e[N_TWO-1-i]) begin
        n_errors++;
        $display("FAIL two_frames_bit%0d: got %b expected %b", i, out_seq, e[N_TWO-1-i]);
      end
      n_checks++;
      if ({busy, done} !== 2'b10) begin
        n_errors++;
        $display("FAIL two_frames_busy%0d: busy,done got %b expected 10", i, {busy, done});
      end
      sh = {sh[2:0], out_seq};
      if (sh == 4'b1010) det++;
      @(negedge clk);
    end
    n_checks++;
    if ({out_seq, busy, done} !== 3'b001) begin
      n_errors++;
      $display("FAIL two_frames_done: got %b expected 001", {out_seq, busy, done});
    end
    @(negedge clk);
    n_checks++;
    if ({out_seq, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL two_frames_after_done: got %b expected 000", {out_seq, busy, done});
    end
    n_checks++;
    if (det != 2) begin
      n_errors++;
      $display("FAIL two_frames_detect: got %0d detections expected 2", det);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    e = EXP_B2B;
    g_start = 1'b1;
    g_num_frames = 8'd3;
    @(negedge clk);
    g_start = 1'b0;
    for (int i = 0; i < int'(N_B2B); i++) begin
      n_checks++;
      if ({g_out_seq, g_busy, g_done} !== {e[N_B2B-1-i], 2'b10}) begin
        n_errors++;
        $display("FAIL b2b_bit%0d: out,busy,done got %b expected %b",
                 i, {g_out_seq, g_busy, g_done}, {e[N_B2B-1-i], 2'b10});
      end
      @(negedge clk);
    end
    n_checks++;
    if ({g_out_seq, g_busy, g_done} !== 3'b001) begin
      n_errors++;
      $display("FAIL b2b_done: got %b expected 001", {g_out_seq, g_busy, g_done});
    end
    @(negedge clk);
  endtask

  task automatic test_zero_frames();
    start = 1'b1;
    num_frames = 8'd0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({out_seq, busy, done} !== 3'b001) begin
      n_errors++;
      $display("FAIL zero_frames_done: got %b expected 001", {out_seq, busy, done});
    end
    @(negedge clk);
    n_checks++;
    if ({out_seq, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL zero_frames_after: got %b expected 000", {out_seq, busy, done});
    end
  endtask

  task automatic test_abort();
    logic [15:0] e;
    e = EXP_ONE;
    // abort wins over a simultaneous start in IDLE
    start = 1'b1;
    abort = 1'b1;
    num_frames = 8'd2;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if ({out_seq, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL abort_beats_start: got %b expected 000", {out_seq, busy, done});
    end
    // abort on the third bit of frame 1
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_seq, busy} !== 2'b11) begin
      n_errors++;
      $display("FAIL abort_third_bit: out,busy got %b expected 11", {out_seq, busy});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({out_seq, busy, done} !== 3'b000) begin
        n_errors++;
        $display("FAIL abort_idle%0d: got %b expected 000", i, {out_seq, busy, done});
      end
      @(negedge clk);
    end
    // fresh start sends a full frame from the MSB
    start = 1'b1;
    num_frames = 8'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(FR); i++) begin
      n_checks++;
      if ({out_seq, busy} !== {e[FR-1-i], 1'b1}) begin
        n_errors++;
        $display("FAIL abort_restart_bit%0d: out,busy got %b expected %b",
                 i, {out_seq, busy}, {e[FR-1-i], 1'b1});
      end
      @(negedge clk);
    end
    n_checks++;
    if ({out_seq, busy, done} !== 3'b001) begin
      n_errors++;
      $display("FAIL abort_restart_done: got %b expected 001", {out_seq, busy, done});
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    e = EXP_ONE;
    start = 1'b1;
    num_frames = 8'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (FR) @(negedge clk);
    n_checks++;
    if ({out_seq, busy} !== 2'b01) begin
      n_errors++;
      $display("FAIL mid_gap: out,busy got %b expected 01", {out_seq, busy});
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({out_seq, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL async_reset: got %b expected 000", {out_seq, busy, done});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    num_frames = 8'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(FR); i++) begin
      n_checks++;
      if ({out_seq, busy} !== {e[FR-1-i], 1'b1}) begin
        n_errors++;
        $display("FAIL post_reset_bit%0d: out,busy got %b expected %b",
                 i, {out_seq, busy}, {e[FR-1-i], 1'b1});
      end
      @(negedge clk);
    end
    n_checks++;
    if ({out_seq, busy, done} !== 3'b001) begin
      n_errors++;
      $display("FAIL post_reset_done: got %b expected 001", {out_seq, busy, done});
    end
    @(negedge clk);
  endtask

  task automatic test_held_start();
    start = 1'b1;
    num_frames = 8'd1;
    @(negedge clk);
    repeat (FR) @(negedge clk);
    n_checks++;
    if ({out_seq, busy, done} !== 3'b001) begin
      n_errors++;
      $display("FAIL held_done: got %b expected 001", {out_seq, busy, done});
    end
    @(negedge clk);
    n_checks++;
    if ({out_seq, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL held_idle_cycle: got %b expected 000", {out_seq, busy, done});
    end
    @(negedge clk);
    n_checks++;
    if ({out_seq, busy, done} !== 3'b110) begin
      n_errors++;
      $display("FAIL held_restart_msb: got %b expected 110", {out_seq, busy, done});
    end
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({out_seq, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL held_abort: got %b expected 000", {out_seq, busy, done});
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    num_frames = 8'd0;
    g_start = 1'b0;
    g_abort = 1'b0;
    g_num_frames = 8'd0;
    test_reset();
    test_two_frames();
    test_back_to_back();
    test_zero_frames();
    test_abort();
    test_async_reset();
    test_held_start();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sequence_generator_moore
